// File: rtl/clk_div_ctrl_if.sv
// Configuration channel for clk_div_ctrl.
// Carries the divide-ratio handshake (cfg_valid/cfg_div/cfg_ready) and the
// result pulses (cfg_done/cfg_err).
//
// Handshake: a ratio transfers on a clk posedge where cfg_valid && cfg_ready.
// The master holds cfg_valid and cfg_div stable until that edge. cfg_ready
// stays low while a legal ratio waits in the pending slot.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_done;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_done,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_done,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free run-time programmable clock divider controller.
// The IDLE/RUN/STOPPING sequencer guarantees whole periods only.
// New ratios arrive on clk_div_ctrl_if and apply at period boundaries, or on
// the next edge when the divider is idle.
// Optional feature macro: CLK_DIV_CTRL_ODD_EN. It adds a negedge phase flop
// so that odd ratios give an exact 50% duty cycle. Without it, odd ratios are
// high for H+1 cycles and low for H cycles.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  clk_div_ctrl_if.slave    cfg,
  output logic [CNT_W-1:0] cur_div,
  output logic             active,
  output logic             clk_out,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cur;
  logic [CNT_W-1:0] r_pend;
  logic             r_ready;
  logic             r_done;
  logic             r_err;
  logic             r_active;
  logic             r_pos;

  state_t           w_state_nxt;
  logic             w_running;
  logic             w_wrap;
  logic             w_apply;
  logic             w_xfer;
  logic             w_legal;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_ceil;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pos_nxt;
  logic             w_neg;

  // Next-state, counter, boundary and ratio-apply decisions.
  always_comb begin
    w_running   = (r_state != S_IDLE);
    w_wrap      = w_running && (r_cnt == (r_cur - ONE));
    // The pending slot is full exactly when cfg_ready is low.
    w_apply     = !r_ready && (!w_running || w_wrap);
    w_div_nxt   = w_apply ? r_pend : r_cur;
    w_xfer      = cfg.cfg_valid && r_ready;
    w_legal     = (cfg.cfg_div >= TWO);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     w_state_nxt = run ? S_RUN : S_IDLE;
      S_RUN:      w_state_nxt = run ? S_RUN : S_STOPPING;
      S_STOPPING: begin
        if (run)         w_state_nxt = S_RUN;
        else if (w_wrap) w_state_nxt = S_IDLE;
        else             w_state_nxt = S_STOPPING;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
    // When leaving IDLE, the counter is parked at N-1. The next edge is then
    // a boundary, and clk_out rises one cycle after run is sampled.
    w_cnt_nxt = '0;
    if (!w_running) begin
      if (w_state_nxt == S_RUN) w_cnt_nxt = w_div_nxt - ONE;
    end else if (!w_wrap && (w_state_nxt != S_IDLE)) begin
      w_cnt_nxt = r_cnt + ONE;
    end
    // The posedge phase is high for ceil(N/2) counts. The negedge phase
    // trims odd ratios by half a cycle when that phase is enabled.
    w_ceil    = w_div_nxt - (w_div_nxt >> 1);
    w_pos_nxt = w_running && (w_state_nxt != S_IDLE) && (w_cnt_nxt < w_ceil);
  end

  // Sequencer FSM, counter, posedge phase and handshake with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cur    <= CNT_W'(DEFAULT_DIV);
      r_pend   <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b0;
      r_pos    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pos    <= w_pos_nxt;
      r_active <= w_running && (w_state_nxt != S_IDLE);
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      if (w_apply) begin
        r_cur   <= r_pend;
        r_ready <= 1'b1;
        r_done  <= 1'b1;
      end else if (w_xfer) begin
        if (w_legal) begin
          r_pend  <= cfg.cfg_div;
          r_ready <= 1'b0;
        end else begin
          r_err   <= 1'b1;
        end
      end
    end
  end

`ifdef CLK_DIV_CTRL_ODD_EN
  logic r_neg;

  // Negedge phase: low for the second half of count H on odd ratios.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) r_neg <= 1'b1;
    else     r_neg <= !((r_state != S_IDLE) && r_cur[0] && (r_cnt == (r_cur >> 1)));
  end

  assign w_neg = r_neg;
`else
  assign w_neg = 1'b1;
`endif

  assign clk_out       = r_pos & w_neg;
  assign active        = r_active;
  assign cur_div       = r_cur;
  assign cfg.cfg_ready = r_ready;
  assign cfg.cfg_done  = r_done;
  assign cfg.cfg_err   = r_err;
  assign dbg_state     = r_state;

endmodule
